// File: rtl/cdb_issue_scheduler_pkg.sv
// Shared definitions for the CDB issue scheduler: unit owner IDs and the
// default execution latencies. The multiplier and divider wrappers use the
// same latency values, so change them here only.
package cdb_issue_scheduler_pkg;

  typedef logic [1:0] owner_t;

  localparam owner_t UNIT_NONE = 2'd0;
  localparam owner_t UNIT_INT  = 2'd1;
  localparam owner_t UNIT_MUL  = 2'd2;
  localparam owner_t UNIT_DIV  = 2'd3;

  localparam int DEF_INT_LAT    = 1;
  localparam int DEF_MUL_LAT    = 3;
  localparam int DEF_DIV_LAT    = 7;
  localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/cdb_issue_scheduler_rsv.sv
// CDB slot-reservation shift register. Entry k holds the owner of the CDB
// slot k cycles ahead; entry 0 is this cycle's owner. Each unit inserts its
// ID at its own latency when granted, and the collision assertion catches
// any grant into a slot that is already owned.
module cdb_rsv_shifter
  import cdb_issue_scheduler_pkg::*;
#(
  parameter int INT_LAT = DEF_INT_LAT,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  ins_int,
  input  logic                  ins_mul,
  input  logic                  ins_div,
  output logic [DIV_LAT:0][1:0] rsv
);

  logic [DIV_LAT:0][1:0] rsv_n;

  // Advance one slot per cycle and OR in the owner IDs of this cycle's grants.
  // A grant at latency L lands in entry L-1 because the shift happens on the
  // same edge.
  always_comb begin
    rsv_n = '0;
    for (int k = 0; k < DIV_LAT; k++) begin
      rsv_n[k] = rsv[k+1];
      if (ins_int && (k + 1) == INT_LAT) rsv_n[k] = rsv_n[k] | UNIT_INT;
      if (ins_mul && (k + 1) == MUL_LAT) rsv_n[k] = rsv_n[k] | UNIT_MUL;
      if (ins_div && (k + 1) == DIV_LAT) rsv_n[k] = rsv_n[k] | UNIT_DIV;
    end
  end

  // Reservation register; reset discards every pending slot.
  always_ff @(posedge clk) begin
    if (!resetb) rsv <= '0;
    else         rsv <= rsv_n;
  end

  // A grant must never target a slot that already has an owner.
  a_no_int_collision: assert property (@(posedge clk) disable iff (!resetb)
    !(ins_int && rsv[INT_LAT] != UNIT_NONE));
  a_no_mul_collision: assert property (@(posedge clk) disable iff (!resetb)
    !(ins_mul && rsv[MUL_LAT] != UNIT_NONE));
  a_no_div_collision: assert property (@(posedge clk) disable iff (!resetb)
    !(ins_div && rsv[DIV_LAT] != UNIT_NONE));

endmodule

// File: rtl/cdb_issue_scheduler.sv
// Issue-side scheduler for ALU, pipelined multiplier and non-pipelined
// divider sharing one CDB write port. Grants are issued only when the
// unit's completion slot is free, so completions never collide on the CDB.
// Also enforces divider occupancy and ALU anti-starvation.
module cdb_issue_scheduler
  import cdb_issue_scheduler_pkg::*;
#(
  parameter int INT_LAT    = DEF_INT_LAT,
  parameter int MUL_LAT    = DEF_MUL_LAT,
  parameter int DIV_LAT    = DEF_DIV_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic       Clk,
  input  logic       Resetb,
  input  logic       Int_Req,
  input  logic       Mul_Req,
  input  logic       Div_Req,
  input  logic       Cdb_Flush,
  output logic       Iss_Int,
  output logic       Iss_Mult,
  output logic       Iss_Div,
  output logic       Cdb_OwnerValid,
  output logic [1:0] Cdb_Owner,
  output logic       Div_Busy,
  output logic       Int_Starve
);

  localparam int DW = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [DW-1:0] DIV_RELOAD = DW'(DIV_LAT - 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  logic [DIV_LAT:0][1:0] rsv;
  logic [DW-1:0]         div_cnt;
  logic [SW-1:0]         starve_cnt;
  logic                  grant_ok;

  // Grants are blocked during reset and while the issue queues purge on a flush.
  assign grant_ok = Resetb && !Cdb_Flush;

  assign Div_Busy   = (div_cnt != '0);
  assign Int_Starve = (starve_cnt == STARVE_TOP);

  // Each grant needs its own completion slot free; MUL/DIV also yield to a starving ALU.
  always_comb begin
    Iss_Int  = grant_ok && Int_Req && (rsv[INT_LAT] == UNIT_NONE);
    Iss_Mult = grant_ok && Mul_Req && (rsv[MUL_LAT] == UNIT_NONE) && !Int_Starve;
    Iss_Div  = grant_ok && Div_Req && (rsv[DIV_LAT] == UNIT_NONE) && !Div_Busy && !Int_Starve;
  end

  assign Cdb_Owner      = rsv[0];
  assign Cdb_OwnerValid = (rsv[0] != UNIT_NONE);

  cdb_rsv_shifter #(
    .INT_LAT (INT_LAT),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_rsv (
    .clk     (Clk),
    .resetb  (Resetb),
    .ins_int (Iss_Int),
    .ins_mul (Iss_Mult),
    .ins_div (Iss_Div),
    .rsv     (rsv)
  );

  // Divider occupancy: reload on issue, count down otherwise. A flush does
  // not stop the divider, so the count keeps running through it.
  always_ff @(posedge Clk) begin
    if (!Resetb)           div_cnt <= '0;
    else if (Iss_Div)      div_cnt <= DIV_RELOAD;
    else if (div_cnt != 0) div_cnt <= div_cnt - 1'b1;
  end

  // ALU starvation counter: counts consecutive denied ALU requests, saturating.
  // A flush cycle neither counts nor clears.
  always_ff @(posedge Clk) begin
    if (!Resetb)                  starve_cnt <= '0;
    else if (Iss_Int || !Int_Req) starve_cnt <= '0;
    else if (Cdb_Flush)           starve_cnt <= starve_cnt;
    else if (!Int_Starve)         starve_cnt <= starve_cnt + 1'b1;
  end

endmodule

// File: tb/tb_cdb_issue_scheduler.sv
// Directed bench for cdb_issue_scheduler. Inputs change 1 time unit after
// the rising edge; outputs are sampled 1 more unit later, mid-cycle.
module tb_cdb_issue_scheduler;

  logic       Clk = 1'b0;
  logic       Resetb, Int_Req, Mul_Req, Div_Req, Cdb_Flush;
  logic       Iss_Int, Iss_Mult, Iss_Div, Cdb_OwnerValid, Div_Busy, Int_Starve;
  logic [1:0] Cdb_Owner;

  int total = 0;
  int bad   = 0;

  cdb_issue_scheduler dut (
    .Clk            (Clk),
    .Resetb         (Resetb),
    .Int_Req        (Int_Req),
    .Mul_Req        (Mul_Req),
    .Div_Req        (Div_Req),
    .Cdb_Flush      (Cdb_Flush),
    .Iss_Int        (Iss_Int),
    .Iss_Mult       (Iss_Mult),
    .Iss_Div        (Iss_Div),
    .Cdb_OwnerValid (Cdb_OwnerValid),
    .Cdb_Owner      (Cdb_Owner),
    .Div_Busy       (Div_Busy),
    .Int_Starve     (Int_Starve)
  );

  always #5 Clk = ~Clk;

  // Advance to the next cycle: just past the edge, inputs may then change.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle(input int n);
    Int_Req = 0; Mul_Req = 0; Div_Req = 0; Cdb_Flush = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    Resetb = 0; Int_Req = 1; Mul_Req = 1; Div_Req = 1; Cdb_Flush = 0;
    tick(); tick(); settle();
    total++;
    if ({Iss_Int, Iss_Mult, Iss_Div} !== 3'b000) begin
      bad++; $display("FAIL reset_grants got=%b want=000", {Iss_Int, Iss_Mult, Iss_Div});
    end
    Int_Req = 0; Mul_Req = 0; Div_Req = 0;
    tick();
    Resetb = 1;
    settle();
    total++;
    if ({Cdb_OwnerValid, Cdb_Owner, Div_Busy, Int_Starve} !== 5'b0) begin
      bad++; $display("FAIL reset_state got=%b want=00000",
                      {Cdb_OwnerValid, Cdb_Owner, Div_Busy, Int_Starve});
    end
  endtask

  task automatic test_mul_single();
    tick();
    Mul_Req = 1; settle();
    total++;
    if ({Iss_Int, Iss_Mult, Iss_Div} !== 3'b010) begin
      bad++; $display("FAIL mul_grant got=%b want=010", {Iss_Int, Iss_Mult, Iss_Div});
    end
    tick(); Mul_Req = 0; settle();
    total++;
    if (Cdb_OwnerValid !== 1'b0) begin bad++; $display("FAIL mul_t1_idle got=%b want=0", Cdb_OwnerValid); end
    tick(); settle();
    total++;
    if (Cdb_OwnerValid !== 1'b0) begin bad++; $display("FAIL mul_t2_idle got=%b want=0", Cdb_OwnerValid); end
    tick(); settle();
    total++;
    if (Cdb_OwnerValid !== 1'b1 || Cdb_Owner !== 2'd2) begin
      bad++; $display("FAIL mul_t3_owner got=%b/%0d want=1/2", Cdb_OwnerValid, Cdb_Owner);
    end
    tick(); settle();
    total++;
    if (Cdb_OwnerValid !== 1'b0) begin bad++; $display("FAIL mul_t4_idle got=%b want=0", Cdb_OwnerValid); end
    idle(4);
  endtask

  task automatic test_int_after_mul();
    Mul_Req = 1; settle();
    total++;
    if (Iss_Mult !== 1'b1) begin bad++; $display("FAIL im_mul_grant got=%b want=1", Iss_Mult); end
    tick(); Mul_Req = 0;
    tick(); Int_Req = 1; settle();
    total++;
    if (Iss_Int !== 1'b0) begin bad++; $display("FAIL im_int_block got=%b want=0", Iss_Int); end
    tick(); settle();
    total++;
    if (Iss_Int !== 1'b1 || Cdb_Owner !== 2'd2) begin
      bad++; $display("FAIL im_int_grant got=%b/%0d want=1/2", Iss_Int, Cdb_Owner);
    end
    tick(); Int_Req = 0; settle();
    total++;
    if (Cdb_Owner !== 2'd1) begin bad++; $display("FAIL im_int_owner got=%0d want=1", Cdb_Owner); end
    idle(4);
  endtask

  task automatic test_all_three();
    logic [1:0] exp_own [1:8];
    exp_own = '{2'd1, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0};
    Int_Req = 1; Mul_Req = 1; Div_Req = 1; settle();
    total++;
    if ({Iss_Int, Iss_Mult, Iss_Div} !== 3'b111) begin
      bad++; $display("FAIL all3_grant got=%b want=111", {Iss_Int, Iss_Mult, Iss_Div});
    end
    tick(); Int_Req = 0; Mul_Req = 0; Div_Req = 0;
    for (int n = 1; n <= 8; n++) begin
      settle();
      total++;
      if (Cdb_Owner !== exp_own[n]) begin
        bad++; $display("FAIL all3_owner t0+%0d got=%0d want=%0d", n, Cdb_Owner, exp_own[n]);
      end
      tick();
    end
    idle(2);
  endtask

  task automatic test_div_busy();
    Div_Req = 1; settle();
    total++;
    if (Iss_Div !== 1'b1 || Div_Busy !== 1'b0) begin
      bad++; $display("FAIL div_first got=%b/%b want=1/0", Iss_Div, Div_Busy);
    end
    for (int n = 1; n <= 6; n++) begin
      tick(); settle();
      total++;
      if (Div_Busy !== 1'b1 || Iss_Div !== 1'b0) begin
        bad++; $display("FAIL div_busy t0+%0d got=%b/%b want=1/0", n, Div_Busy, Iss_Div);
      end
    end
    tick(); settle();
    total++;
    if (Div_Busy !== 1'b0 || Iss_Div !== 1'b1 || Cdb_Owner !== 2'd3) begin
      bad++; $display("FAIL div_reissue got=%b/%b/%0d want=0/1/3", Div_Busy, Iss_Div, Cdb_Owner);
    end
    idle(10);
  endtask

  task automatic test_starve();
    Mul_Req = 1;
    for (int i = 0; i < 6; i++) tick();
    Int_Req = 1;
    for (int n = 0; n <= 3; n++) begin
      settle();
      total++;
      if (Iss_Int !== 1'b0 || Int_Starve !== 1'b0 || Iss_Mult !== 1'b1) begin
        bad++; $display("FAIL starve_pre t0+%0d got=%b%b%b want=001", n, Iss_Int, Int_Starve, Iss_Mult);
      end
      tick();
    end
    settle();
    total++;
    if (Int_Starve !== 1'b1 || Iss_Mult !== 1'b0 || Iss_Int !== 1'b0) begin
      bad++; $display("FAIL starve_on got=%b%b%b want=100", Int_Starve, Iss_Mult, Iss_Int);
    end
    tick(); settle();
    total++;
    if (Iss_Int !== 1'b0 || Iss_Mult !== 1'b0 || Int_Starve !== 1'b1) begin
      bad++; $display("FAIL starve_t5 got=%b%b%b want=001", Iss_Int, Iss_Mult, Int_Starve);
    end
    tick(); settle();
    total++;
    if (Iss_Int !== 1'b1) begin bad++; $display("FAIL starve_int_grant got=%b want=1", Iss_Int); end
    tick(); settle();
    total++;
    if (Int_Starve !== 1'b0 || Cdb_Owner !== 2'd1) begin
      bad++; $display("FAIL starve_release got=%b/%0d want=0/1", Int_Starve, Cdb_Owner);
    end
    idle(6);
  endtask

  task automatic test_flush();
    Mul_Req = 1; settle();
    total++;
    if (Iss_Mult !== 1'b1) begin bad++; $display("FAIL fl_mul_grant got=%b want=1", Iss_Mult); end
    tick();
    Int_Req = 1; Div_Req = 1; Cdb_Flush = 1; settle();
    total++;
    if ({Iss_Int, Iss_Mult, Iss_Div} !== 3'b000) begin
      bad++; $display("FAIL fl_no_grant got=%b want=000", {Iss_Int, Iss_Mult, Iss_Div});
    end
    tick();
    Int_Req = 0; Mul_Req = 0; Div_Req = 0; Cdb_Flush = 0; settle();
    total++;
    if (Cdb_OwnerValid !== 1'b0 || Div_Busy !== 1'b0 || Int_Starve !== 1'b0) begin
      bad++; $display("FAIL fl_t2 got=%b%b%b want=000", Cdb_OwnerValid, Div_Busy, Int_Starve);
    end
    tick(); settle();
    total++;
    if (Cdb_Owner !== 2'd2) begin bad++; $display("FAIL fl_kept_rsv got=%0d want=2", Cdb_Owner); end
    idle(4);
  endtask

  task automatic test_reset_mid();
    Mul_Req = 1; settle();
    total++;
    if (Iss_Mult !== 1'b1) begin bad++; $display("FAIL rm_mul_grant got=%b want=1", Iss_Mult); end
    tick();
    Mul_Req = 0; Int_Req = 1; Resetb = 0; settle();
    total++;
    if (Iss_Int !== 1'b0) begin bad++; $display("FAIL rm_int_in_reset got=%b want=0", Iss_Int); end
    tick();
    Resetb = 1; Int_Req = 0;
    tick(); settle();
    total++;
    if (Cdb_OwnerValid !== 1'b0 || Cdb_Owner !== 2'd0) begin
      bad++; $display("FAIL rm_discard got=%b/%0d want=0/0", Cdb_OwnerValid, Cdb_Owner);
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_mul_single();
    test_int_after_mul();
    test_all_three();
    test_div_busy();
    test_starve();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
